// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HH:MM:SS BCD time-of-day counter with 1 Hz prescaler and button set-mode FSM.
module bcd_time_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hour_lo,
  output logic [3:0] hour_hi,
  output logic [1:0] mode,
  output logic       tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, BAD = 2'd3} mode_t;
  mode_t mode_q, mode_d;
  logic [W-1:0] pre_q, pre_d;
  logic tick_q, tick_d, prev_mode_q, prev_inc_q;
  logic [3:0] sl_q, sh_q, ml_q, mh_q, hl_q, hh_q;
  logic [3:0] sl_d, sh_d, ml_d, mh_d, hl_d, hh_d;
  logic mode_edge, inc_edge, run, wrap;
  logic s_lo_max, s_max, m_lo_max, m_max, h_max;
  logic [3:0] sl_inc, sh_inc, ml_inc, mh_inc, hl_inc, hh_inc;
  assign mode_edge = btn_mode & ~prev_mode_q;
  assign inc_edge  = btn_inc & ~prev_inc_q;
  assign run       = mode_q == RUN;
  assign wrap      = run && en && pre_q == LAST;
  assign s_lo_max  = sl_q == 4'd9;
  assign s_max     = s_lo_max && sh_q == 4'd5;
  assign m_lo_max  = ml_q == 4'd9;
  assign m_max     = m_lo_max && mh_q == 4'd5;
  assign h_max     = hh_q == 4'd2 && hl_q == 4'd3;
  assign sl_inc    = s_lo_max ? 4'd0 : sl_q + 4'd1;
  assign sh_inc    = s_max ? 4'd0 : s_lo_max ? sh_q + 4'd1 : sh_q;
  assign ml_inc    = m_lo_max ? 4'd0 : ml_q + 4'd1;
  assign mh_inc    = m_max ? 4'd0 : m_lo_max ? mh_q + 4'd1 : mh_q;
  assign hl_inc    = (h_max || hl_q == 4'd9) ? 4'd0 : hl_q + 4'd1;
  assign hh_inc    = h_max ? 4'd0 : hl_q == 4'd9 ? hh_q + 4'd1 : hh_q;
  always_comb begin
    mode_d = mode_q;
    tick_d = wrap;
    {sl_d, sh_d, ml_d, mh_d, hl_d, hh_d} = {sl_q, sh_q, ml_q, mh_q, hl_q, hh_q};
    // Any mode transition leaves the prescaler at 0, so the first RUN second is a full one.
    pre_d = (!run || mode_edge || wrap) ? '0 : en ? pre_q + 1'b1 : pre_q;
    if (mode_edge)
      mode_d = mode_q == RUN ? SET_HOUR : mode_q == SET_HOUR ? SET_MIN : RUN;
    if (wrap) begin
      {sl_d, sh_d} = {sl_inc, sh_inc};
      if (s_max) {ml_d, mh_d} = {ml_inc, mh_inc};
      if (s_max && m_max) {hl_d, hh_d} = {hl_inc, hh_inc};
    end
    if (inc_edge && !mode_edge && mode_q == SET_HOUR) {hl_d, hh_d} = {hl_inc, hh_inc};
    if (inc_edge && !mode_edge && mode_q == SET_MIN) {ml_d, mh_d} = {ml_inc, mh_inc};
    if (mode_edge && mode_q == SET_MIN) {sl_d, sh_d} = 8'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q      <= RUN;
      pre_q       <= '0;
      tick_q      <= 1'b0;
      prev_mode_q <= 1'b0;
      prev_inc_q  <= 1'b0;
      {sl_q, sh_q, ml_q, mh_q, hl_q, hh_q} <= '0;
    end else begin
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      prev_mode_q <= btn_mode;
      prev_inc_q  <= btn_inc;
      {sl_q, sh_q, ml_q, mh_q, hl_q, hh_q} <= {sl_d, sh_d, ml_d, mh_d, hl_d, hh_d};
    end
  assign {sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi} = {sl_q, sh_q, ml_q, mh_q, hl_q, hh_q};
  assign mode = mode_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed checks of counting, rollover, set modes and reset with TICK_DIV=4.
module tb_bcd_time_counter;
  logic clk, rst, en, btn_mode, btn_inc;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
  logic [1:0] mode;
  logic tick;
  logic [23:0] tm;
  int n_cmp, n_bad, ticks, first, last;
  bcd_time_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .hour_lo(hour_lo), .hour_hi(hour_hi), .mode(mode), .tick(tick)
  );
  assign tm = {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    step(1);
  endtask
  task automatic pulse_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1;
      step(1);
      btn_inc = 1'b0;
      step(1);
    end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    en = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(2);
    rst = 1'b0;
    chk("reset_time", tm, 24'h000000);
    chk("reset_mode", mode, 2'd0);
    chk("reset_tick", tick, 1'b0);
    en = 1'b1;
    ticks = 0;
    first = 0;
    last = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (tick) begin
        ticks++;
        if (first == 0) first = i;
        last = i;
      end
    end
    chk("count_time", tm, 24'h000003);
    chk("count_ticks", ticks, 3);
    chk("count_first", first, 4);
    chk("count_last", last, 12);
    en = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick) ticks++;
    end
    chk("hold_time", tm, 24'h000003);
    chk("hold_ticks", ticks, 0);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step(1);
    chk("both_mode", mode, 2'd1);
    chk("both_time", tm, 24'h000003);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(1);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(1);
    chk("held_inc", tm, 24'h010003);
    pulse_inc(24);
    chk("hour_wrap25", tm, 24'h010003);
    chk("hour_mode", mode, 2'd1);
    pulse_inc(22);
    chk("hour_23", tm, 24'h230003);
    pulse_mode();
    chk("setmin_mode", mode, 2'd2);
    pulse_inc(59);
    chk("min_59", tm, 24'h235903);
    pulse_inc(1);
    chk("min_wrap", tm, 24'h230003);
    pulse_inc(59);
    en = 1'b1;
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    chk("leave_mode", mode, 2'd0);
    chk("leave_time", tm, 24'h235900);
    step(3);
    chk("leave_tick0", tick, 1'b0);
    step(1);
    chk("leave_tick1", tick, 1'b1);
    chk("leave_sec1", tm, 24'h235901);
    step(4 * 58);
    chk("pre_wrap", tm, 24'h235959);
    step(3);
    chk("pre_wrap_hold", tm, 24'h235959);
    step(1);
    chk("day_wrap", tm, 24'h000000);
    chk("day_wrap_tick", tick, 1'b1);
    step(3);
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    chk("wrap_mode_time", tm, 24'h000001);
    chk("wrap_mode_mode", mode, 2'd1);
    chk("wrap_mode_tick", tick, 1'b1);
    step(1);
    chk("sethour_notick", tick, 1'b0);
    pulse_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    chk("back_run", tm, 24'h000000);
    step(9);
    chk("mid_count", tm, 24'h000002);
    rst = 1'b1;
    #2;
    chk("async_time", tm, 24'h000000);
    chk("async_mode", mode, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(3);
    chk("rel_tick0", tick, 1'b0);
    step(1);
    chk("rel_tick1", tick, 1'b1);
    chk("rel_time", tm, 24'h000001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Upstream stage of the digital-clock display path: keeps time of day as six BCD digits (HH:MM:SS) and feeds each digit to one seven-segment decoder instance.
- Contains a prescaler that turns the board clock into a 1 Hz advance, BCD counters with ripple carries, and a small mode FSM for setting hours and minutes from two buttons.
- Every digit output is always a legal BCD value 0-9, so the decoder never receives a blank code.

Parameters:
- TICK_DIV, 50000000: clock cycles per one-second advance; must be >= 2. The prescaler width is clog2(TICK_DIV).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- en  in  1  run enable; level-sensitive and only meaningful in RUN.
- btn_mode  in  1  mode button level, already synchronised to clk; a rising edge advances the mode.
- btn_inc  in  1  increment button level, already synchronised to clk; a rising edge increments the field being set.
- sec_lo  out  4  seconds ones digit, 0-9.
- sec_hi  out  4  seconds tens digit, 0-5.
- min_lo  out  4  minutes ones digit, 0-9.
- min_hi  out  4  minutes tens digit, 0-5.
- hour_lo  out  4  hours ones digit, 0-9.
- hour_hi  out  4  hours tens digit, 0-2.
- mode  out  2  current mode: 0=RUN, 1=SET_HOUR, 2=SET_MIN.
- tick  out  1  one-cycle pulse, high in the cycle the seconds value has just advanced.

Behaviour:
- Reset state:
  - all six digits 0 (00:00:00);
  - prescaler 0, mode RUN, tick 0;
  - button history registers 0.
  - Reset asserted mid-count clears outputs asynchronously; the first advance after release comes TICK_DIV enabled cycles later.
- Edge detection:
  - prev_mode and prev_inc are registered every cycle in every mode.
  - edge = level AND NOT prev.
  - A held button produces exactly one edge.
- Prescaler, in RUN with en=1:
  - counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1: prescaler goes to 0, time advances by one second, tick goes to 1.
  - On every other edge, tick goes to 0.
  - With en=0 in RUN: prescaler and digits hold, tick is 0.
- Time advance, on the same edge:
  - sec_lo 9->0 with carry into sec_hi;
  - sec_hi 5->0 with carry into minutes;
  - minutes roll over the same way (min_lo 9->0, min_hi 5->0), carrying into hours;
  - hours count 00..23 and go from 23 to 00.
  - 23:59:59 -> 00:00:00 in a single edge, no intermediate value visible.
- Mode FSM, driven by mode edges:
  - RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR: prescaler cleared to 0.
  - In SET_HOUR and SET_MIN: prescaler held at 0, no time advance, tick=0, en ignored.
  - Leaving SET_MIN for RUN: seconds cleared to 00 and prescaler 0, so the first advance comes TICK_DIV cycles after the transition edge.
  - Encoding 3 is unreachable; if ever present, the next edge returns to RUN.
- Increment edges:
  - SET_HOUR: hours +1 modulo 24 (23 -> 00); minutes and seconds untouched.
  - SET_MIN: minutes +1 modulo 60 (59 -> 00); no carry into hours.
  - RUN: ignored.
- Simultaneous events:
  - Mode edge and inc edge in the same cycle: the mode change wins and the inc is discarded.
  - Seconds wrap and a mode edge from RUN in the same cycle: the time advance is applied and the mode moves to SET_HOUR.
- Latency: a button edge is visible on outputs one cycle after the level rises (the registered edge acts on the next clk edge).

Test Plan:
- TICK_DIV=4, rst pulse, en=1, 12 cycles -> digits 00:00:03, tick high exactly 3 cycles, 4 cycles apart.
- TICK_DIV=4, preload 23:59:59 via set mode plus counting, one more advance -> 00:00:00 in a single cycle, tick=1.
- Mode edge, then 25 inc edges -> mode=1, hours reach 01 (wrap at 24), minutes and seconds unchanged.
- In SET_MIN with minutes=59, one inc -> minutes 00, hours unchanged; mode edge -> mode=0, seconds 00, first tick 4 cycles later.
- btn_mode and btn_inc rise together in RUN -> mode=1, hours unchanged; btn_inc held high 10 cycles in SET_HOUR -> hours +1 only.
- en=0 for 20 cycles in RUN -> digits frozen, tick 0; rst asserted mid-count (time 00:00:02) -> outputs 0 before next clk edge.
